// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM line port between NUM_REQ engines.
// Optional `SRAM_ARB_FIXED_PRIO_EN: requester 0 (scan-out) always wins when it is requesting.
//
// state   | meaning
// S_IDLE  | arbitrate; grant pulses combinationally, command latched at the edge
// S_READ  | read_enable high for one cycle at the latched address
// S_RDATA | SRAM read data returned to the winner with rsp_valid
// S_WRITE | write_enable held WRITE_CYCLES cycles; rsp_valid on the last one
// S_ERR   | address out of range: no strobe, rsp_valid with rsp_error
module sram_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64,
    parameter int WRITE_CYCLES    = 2,
    parameter int ADDR_LIMIT      = 208896,
    localparam int DW             = WORD_SIZE_BYTES * DATA_SIZE_WORDS * 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDR_SIZE_BITS-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0]             req_wdata,
    output logic [NUM_REQ-1:0]                req_grant,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DW-1:0]                     rsp_data,
    output logic                              rsp_error,
    output logic                              read_enable,
    output logic                              write_enable,
    output logic [ADDR_SIZE_BITS-1:0]         address,
    output logic [DW-1:0]                     write_data,
    input  logic [DW-1:0]                     read_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RDATA,
        S_WRITE,
        S_ERR
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [PTR_W-1:0]          rr_ptr;
    logic [PTR_W-1:0]          lat_w;
    logic [ADDR_SIZE_BITS-1:0] lat_addr;
    logic [DW-1:0]             lat_wdata;
    logic [CNT_W-1:0]          wr_cnt;

    logic                      found;
    logic [PTR_W-1:0]          win;
    logic [PTR_W-1:0]          cand;
    logic [ADDR_SIZE_BITS-1:0] sel_addr;
    logic [DW-1:0]             sel_wdata;
    logic                      sel_write;
    logic                      sel_illegal;
    logic [NUM_REQ-1:0]        win_onehot;
    logic [NUM_REQ-1:0]        lat_onehot;

    // Winner search starts one past the last winner and wraps.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        if (req_valid[0]) begin
            found = 1'b1;
            win   = '0;
        end else begin
            for (int k = 1; k < NUM_REQ; k++) begin
                cand = PTR_W'(((int'(rr_ptr) - 1 + k) % (NUM_REQ - 1)) + 1);
                if (!found && req_valid[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
`endif
    end

    assign sel_addr    = req_addr[win*ADDR_SIZE_BITS +: ADDR_SIZE_BITS];
    assign sel_wdata   = req_wdata[win*DW +: DW];
    assign sel_write   = req_write[win];
    assign sel_illegal = (sel_addr >= ADDR_SIZE_BITS'(ADDR_LIMIT));
    assign win_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
    assign lat_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << lat_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= PTR_W'(NUM_REQ - 1);
            lat_w     <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wr_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && found) begin
                lat_w     <= win;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                wr_cnt    <= CNT_W'(WRITE_CYCLES - 1);
`ifdef SRAM_ARB_FIXED_PRIO_EN
                if (win != '0) begin
                    rr_ptr <= win;
                end
`else
                rr_ptr    <= win;
`endif
            end else if (state == S_WRITE && wr_cnt != '0) begin
                wr_cnt <= wr_cnt - CNT_W'(1);
            end
        end
    end

    // Moore outputs from the latched command; only the grant looks at live inputs.
    always_comb begin
        state_nxt    = state;
        req_grant    = '0;
        rsp_valid    = '0;
        rsp_data     = '0;
        rsp_error    = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        write_data   = '0;
        case (state)
            S_IDLE: begin
                if (found && !rst) begin
                    req_grant = win_onehot;
                end
                if (found) begin
                    if (sel_illegal) begin
                        state_nxt = S_ERR;
                    end else if (sel_write) begin
                        state_nxt = S_WRITE;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                read_enable = 1'b1;
                address     = lat_addr;
                state_nxt   = S_RDATA;
            end
            S_RDATA: begin
                rsp_valid = lat_onehot;
                rsp_data  = read_data;
                state_nxt = S_IDLE;
            end
            S_WRITE: begin
                write_enable = 1'b1;
                address      = lat_addr;
                write_data   = lat_wdata;
                if (wr_cnt == '0) begin
                    rsp_valid = lat_onehot;
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                rsp_valid = lat_onehot;
                rsp_error = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a vector table of single transactions plus
// hand-written sequences for round-robin fairness, mid-write reset and request withdrawal.
module tb_sram_arbiter;

    localparam int NR = 4;
    localparam int AW = 24;
    localparam int DW = 1536;
    localparam int WC = 2;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_grant;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_error;
    logic              read_enable;
    logic              write_enable;
    logic [AW-1:0]     address;
    logic [DW-1:0]     write_data;
    logic [DW-1:0]     read_data;

    logic [AW-1:0]     a_arr [NR];
    logic [DW-1:0]     d_arr [NR];

    int n_vec = 0;
    int n_bad = 0;

    sram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_grant    (req_grant),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = a_arr[i];
            req_wdata[i*DW +: DW] = d_arr[i];
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic        write;
        int          win;
        logic [23:0] addr;
        logic [3:0]  exp_grant;
        logic        exp_err;
    } vec_t;

    vec_t vt [10];

    function automatic logic [DW-1:0] pat(input int k);
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < DW / 32; i++) begin
            p[i*32 +: 32] = 32'hA500_0000 ^ (32'(k) * 32'h0101_0101) ^ 32'(i);
        end
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ...%h expected ...%h", nm, act[63:0], exp[63:0]);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_write = '0;
        read_data = '0;
        for (int i = 0; i < NR; i++) begin
            a_arr[i] = '0;
            d_arr[i] = '0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 64'(req_grant), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_error", 64'(rsp_error), 64'(0));
        chk("rst_re", 64'(read_enable), 64'(0));
        chk("rst_we", 64'(write_enable), 64'(0));
        chk("rst_address", 64'(address), 64'(0));
        chkd("rst_write_data", write_data, '0);
        chkd("rst_rsp_data", rsp_data, '0);
    endtask

    // Called just after a negedge; samples 1 time unit later each cycle.
    task automatic wait_grant(output logic [3:0] g);
        g = '0;
        for (int n = 0; n < 20 && g == 0; n++) begin
            #1;
            if (req_grant != 0) g = req_grant;
            else @(negedge clk);
        end
    endtask

    // Entered in the grant cycle; returns at the negedge of the response cycle.
    task automatic run_txn(input logic [3:0] g, input logic wr, input logic er,
                           input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, input logic [3:0] drop);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~drop;
        read_data = ~rd;
        @(negedge clk);
        chk("busy_grant", 64'(req_grant), 64'(0));
        if (er) begin
            chk("err_re", 64'(read_enable), 64'(0));
            chk("err_we", 64'(write_enable), 64'(0));
            chk("err_rsp_valid", 64'(rsp_valid), 64'(g));
            chk("err_flag", 64'(rsp_error), 64'(1));
            chkd("err_rsp_data", rsp_data, '0);
        end else if (wr) begin
            for (int c = 1; c <= WC; c++) begin
                if (c > 1) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                end
                chk("wr_we", 64'(write_enable), 64'(1));
                chk("wr_re", 64'(read_enable), 64'(0));
                chk("wr_address", 64'(address), 64'(ad));
                chkd("wr_data", write_data, wd);
                chk("wr_rsp_valid", 64'(rsp_valid), (c == WC) ? 64'(g) : 64'(0));
            end
        end else begin
            chk("rd_re", 64'(read_enable), 64'(1));
            chk("rd_we", 64'(write_enable), 64'(0));
            chk("rd_address", 64'(address), 64'(ad));
            chk("rd_rsp_early", 64'(rsp_valid), 64'(0));
            @(posedge clk);
            #1;
            read_data = rd;
            @(negedge clk);
            chk("rd_re_off", 64'(read_enable), 64'(0));
            chk("rd_rsp_valid", 64'(rsp_valid), 64'(g));
            chk("rd_rsp_error", 64'(rsp_error), 64'(0));
            chkd("rd_rsp_data", rsp_data, rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        logic [3:0] eg;
        int w;

        vt[0] = '{4'b0010, 1'b0, 1, 24'h000040, 4'b0010, 1'b0};
        vt[1] = '{4'b0001, 1'b1, 0, 24'h023000, 4'b0001, 1'b0};
        vt[2] = '{4'b0100, 1'b0, 2, 24'h033000, 4'b0100, 1'b1};
        vt[3] = '{4'b1111, 1'b0, 3, 24'h000100, 4'b1000, 1'b0};
        vt[4] = '{4'b1111, 1'b0, 0, 24'h000200, 4'b0001, 1'b0};
        vt[5] = '{4'b1010, 1'b1, 1, 24'h000300, 4'b0010, 1'b0};
        vt[6] = '{4'b1001, 1'b0, 3, 24'h000400, 4'b1000, 1'b0};
        vt[7] = '{4'b0110, 1'b0, 1, 24'h032FFF, 4'b0010, 1'b0};
        vt[8] = '{4'b0001, 1'b0, 0, 24'hFFFFFF, 4'b0001, 1'b1};
        vt[9] = '{4'b1100, 1'b1, 2, 24'h033000, 4'b0100, 1'b1};

        do_reset();

`ifndef SRAM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NR; i++) begin
                a_arr[i] = (i == vt[k].win) ? vt[k].addr : (24'hF00000 | 24'(i));
                d_arr[i] = (i == vt[k].win) ? pat(k) : ~pat(k);
            end
            req_write = vt[k].write ? 4'hF : 4'h0;
            req_valid = vt[k].valid;
            wait_grant(g);
            chk("vec_grant", 64'(g), 64'(vt[k].exp_grant));
            chk("idle_re", 64'(read_enable), 64'(0));
            chk("idle_we", 64'(write_enable), 64'(0));
            chk("idle_address", 64'(address), 64'(0));
            chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
            run_txn(vt[k].exp_grant, vt[k].write, vt[k].exp_err, vt[k].addr,
                    pat(k), pat(k + 100), 4'hF);
        end
`endif

        // All four requesters hold req_valid continuously.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            a_arr[i] = 24'h001000 + 24'(i * 'h40);
            d_arr[i] = pat(50 + i);
        end
        req_write = 4'h0;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = k % NR;
`endif
            eg = 4'(1 << w);
            wait_grant(g);
            chk("rr_grant", 64'(g), 64'(eg));
            run_txn(eg, 1'b0, 1'b0, a_arr[w], d_arr[w], pat(200 + k), 4'h0);
        end
        req_valid = 4'h0;

        // Reset during the first write cycle abandons the write.
        do_reset();
        a_arr[2]  = 24'h000500;
        d_arr[2]  = pat(300);
        req_write = 4'b0100;
        req_valid = 4'b0100;
        wait_grant(g);
        chk("t5_grant", 64'(g), 64'(4'b0100));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_rsp_in_rst", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_we_after", 64'(write_enable), 64'(0));
        chk("t5_rsp_after", 64'(rsp_valid), 64'(0));
        chk("t5_addr_after", 64'(address), 64'(0));
        chk("t5_regrant", 64'(req_grant), 64'(4'b0100));
        run_txn(4'b0100, 1'b1, 1'b0, 24'h000500, pat(300), '0, 4'hF);

        // req3 withdraws while req1 is served; req0 arrives and is next.
        do_reset();
        a_arr[0]  = 24'h000800;
        d_arr[0]  = pat(401);
        a_arr[1]  = 24'h000600;
        d_arr[1]  = pat(400);
        a_arr[3]  = 24'h000700;
        d_arr[3]  = pat(404);
        req_write = 4'h0;
        req_valid = 4'b1010;
        wait_grant(g);
        chk("t6_grant1", 64'(g), 64'(4'b0010));
        run_txn(4'b0010, 1'b0, 1'b0, 24'h000600, pat(400), pat(402), 4'b0010);
        req_valid = 4'b0001;
        wait_grant(g);
        chk("t6_grant0", 64'(g), 64'(4'b0001));
        run_txn(4'b0001, 1'b0, 1'b0, 24'h000800, pat(401), pat(403), 4'b0001);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("t6_no_grant", 64'(req_grant), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
